// File: rtl/popcount_datapath_pkg.sv
// popcount_datapath_pkg: shared width defaults and control FSM state encodings
package popcount_datapath_pkg;
  localparam int DEF_WIDTH = 8;
  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction
  typedef enum logic [2:0] {START, CHECK1, ADD, SHIFT, CHECK2, DONE} fsm_state_t;
endpackage

// File: rtl/popcount_datapath.sv
// popcount_datapath: operand/count registers driven by the ones-counting control FSM strobes
module popcount_datapath
  import popcount_datapath_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = cnt_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             init,
  input  logic             out_rst,
  input  logic             sft,
  input  logic             add,
  input  logic             done,
  output logic             a0,
  output logic             z,
  output logic [CNT_W-1:0] result,
  output logic             result_valid,
  input  logic             result_ack
);
  logic [WIDTH-1:0] a;
  logic [CNT_W-1:0] c;
  logic             busy;
  assign in_ready = ~busy & (~result_valid | result_ack);
  assign init     = busy;
  assign a0       = a[0];
  assign z        = |a;
  // later assignments win: a done capture overrides a coinciding ack
  always_ff @(posedge clk) begin
    if (rst) begin
      a            <= '0;
      c            <= '0;
      result       <= '0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        a    <= data_in;
        c    <= '0;
        busy <= 1'b1;
      end
      if (out_rst) c <= '0;
      if (add) c <= c + CNT_W'(1);
      if (sft) a <= a >> 1;
      if (result_ack) result_valid <= 1'b0;
      if (done && busy) begin
        result       <= c;
        result_valid <= 1'b1;
        busy         <= 1'b0;
      end
    end
  end
endmodule
